// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions for the write-back stage.
// Contents: write-back source select codes, load funct3 codes and the
// MEM/WB pipeline register layout.
package riscv_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
        logic [31:0] load_data;
    } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   raw_word   in  32  aligned 32-bit word read from data memory
//   addr_lo    in  2   byte offset of the load address
//   funct3     in  3   RV32I load width/sign encoding
//   load_value out 32  aligned, sign/zero-extended load result
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        // Misaligned halfwords simply drop addr_lo[0]; traps are raised elsewhere.
        half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

        case (funct3)
            F3_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_value = {24'b0, byte_sel};
            F3_LH:   load_value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_value = {16'b0, half_sel};
            F3_LW:   load_value = raw_word;
            default: load_value = raw_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage of the five-stage RV32I pipeline.
// Holds the MEM/WB register, selects the write-back source, gates the
// register-file write strobe and counts retired instructions.
// Ports:
//   clock, reset (sync, active-high), stall, flush  pipeline control
//   m_*              memory-stage instruction fields captured into MEM/WB
//   wb_addr_rd/wb_data_rd/wb_write_enable           register-file write port
//   wb_pc, wb_valid  trace of the instruction in WB
//   instret          retired-instruction counter (wraps)
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [XLEN-1:0]  m_pc,
    input  logic [4:0]       m_rd,
    input  logic             m_reg_we,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_funct3,
    input  logic [1:0]       m_addr_lo,
    input  logic [XLEN-1:0]  m_alu_result,
    input  logic [XLEN-1:0]  m_load_data,
    output logic [XLEN-1:0]  wb_addr_rd,
    output logic [XLEN-1:0]  wb_data_rd,
    output logic             wb_write_enable,
    output logic [XLEN-1:0]  wb_pc,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret
);

    mem_wb_t          mem_wb_d, mem_wb_q;
    logic [CNT_W-1:0] instret_d, instret_q;
    logic             retire;
    logic [31:0]      load_value;

    // The occupant leaves WB whenever the register is not held; a flush
    // overrides stall, so the occupant still retires in that case.
    assign retire = mem_wb_q.valid & (~stall | flush);

    always_comb begin
        mem_wb_d  = mem_wb_q;
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
        if (reset) begin
            mem_wb_d  = '0;
            instret_d = '0;
        end else if (flush) begin
            mem_wb_d       = mem_wb_q;
            mem_wb_d.valid = 1'b0;
        end else if (!stall) begin
            mem_wb_d.valid      = m_valid;
            mem_wb_d.pc         = m_pc;
            mem_wb_d.rd         = m_rd;
            mem_wb_d.reg_we     = m_reg_we;
            mem_wb_d.wb_sel     = m_wb_sel;
            mem_wb_d.funct3     = m_funct3;
            mem_wb_d.addr_lo    = m_addr_lo;
            mem_wb_d.alu_result = m_alu_result;
            mem_wb_d.load_data  = m_load_data;
        end
    end

    always_ff @(posedge clock) begin
        mem_wb_q  <= mem_wb_d;
        instret_q <= instret_d;
    end

    load_align u_load_align (
        .raw_word   (mem_wb_q.load_data),
        .addr_lo    (mem_wb_q.addr_lo),
        .funct3     (mem_wb_q.funct3),
        .load_value (load_value)
    );

    always_comb begin
        unique case (mem_wb_q.wb_sel)
            WB_SEL_ALU:  wb_data_rd = mem_wb_q.alu_result;
            WB_SEL_LOAD: wb_data_rd = load_value;
            WB_SEL_PC4:  wb_data_rd = mem_wb_q.pc + 32'd4;  // wraps modulo 2^32
            default:     wb_data_rd = '0;
        endcase
    end

    // Writes to x0 and reserved sources are suppressed; the strobe stays high
    // through a stall because re-writing the same value is harmless.
    assign wb_write_enable = mem_wb_q.valid & mem_wb_q.reg_we & (mem_wb_q.rd != 5'd0) &
                             (mem_wb_q.wb_sel != WB_SEL_RSVD);
    assign wb_addr_rd      = {27'b0, mem_wb_q.rd};
    assign wb_pc           = mem_wb_q.pc;
    assign wb_valid        = mem_wb_q.valid;
    assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_result, m_load_data;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb_sel, m_addr_lo;
    logic [2:0]  m_funct3;
    logic [31:0] wb_addr_rd, wb_data_rd, wb_pc;
    logic        wb_write_enable, wb_valid;
    logic [63:0] instret;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .m_valid         (m_valid),
        .m_pc            (m_pc),
        .m_rd            (m_rd),
        .m_reg_we        (m_reg_we),
        .m_wb_sel        (m_wb_sel),
        .m_funct3        (m_funct3),
        .m_addr_lo       (m_addr_lo),
        .m_alu_result    (m_alu_result),
        .m_load_data     (m_load_data),
        .wb_addr_rd      (wb_addr_rd),
        .wb_data_rd      (wb_data_rd),
        .wb_write_enable (wb_write_enable),
        .wb_pc           (wb_pc),
        .wb_valid        (wb_valid),
        .instret         (instret)
    );

    always #5 clock = ~clock;

    // Register file stand-in: commits on the edge after the write is presented.
    logic [31:0] regs [32];
    always @(posedge clock) begin
        if (wb_write_enable === 1'b1) regs[wb_addr_rd[4:0]] <= wb_data_rd;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instruction sitting in WB plus the retire count.
    logic        r_valid = 1'b0, r_we = 1'b0;
    logic [31:0] r_pc = '0, r_alu = '0, r_raw = '0;
    logic [4:0]  r_rd = '0;
    logic [1:0]  r_sel = '0, r_lo = '0;
    logic [2:0]  r_f3 = '0;
    bit          r_known = 1'b0;
    longint unsigned r_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [31:0] exp_data;
        logic        exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] raw, input int lo, input int f3);
        int unsigned b, h;
        b = (raw >> (8 * lo)) & 32'hFF;
        h = (raw >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4:       return b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5:       return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic exp_we_f();
        return r_valid && r_we && (r_rd != 0) && (r_sel != 2'd3);
    endfunction

    function automatic logic [31:0] exp_data_f();
        case (r_sel)
            2'd0:    return r_alu;
            2'd1:    return ref_load(r_raw, int'(r_lo), int'(r_f3));
            2'd2:    return r_pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            r_valid = 0; r_we = 0; r_pc = 0; r_alu = 0; r_raw = 0;
            r_rd = 0; r_sel = 0; r_lo = 0; r_f3 = 0; r_known = 1; r_cnt = 0;
        end else begin
            if (r_valid && (!stall || flush)) r_cnt++;
            if (flush) begin
                r_valid = 0;
                r_known = 0;
            end else if (!stall) begin
                r_valid = m_valid; r_we = m_reg_we; r_pc = m_pc; r_alu = m_alu_result;
                r_raw = m_load_data; r_rd = m_rd; r_sel = m_wb_sel; r_lo = m_addr_lo;
                r_f3 = m_funct3; r_known = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " valid"}, {63'b0, wb_valid}, {63'b0, r_valid});
        check({tag, " we"}, {63'b0, wb_write_enable}, {63'b0, exp_we_f()});
        check({tag, " instret"}, instret, r_cnt);
        if (r_known) begin
            check({tag, " addr"}, {32'b0, wb_addr_rd}, {59'b0, r_rd});
            check({tag, " data"}, {32'b0, wb_data_rd}, {32'b0, exp_data_f()});
            check({tag, " pc"}, {32'b0, wb_pc}, {32'b0, r_pc});
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_op(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic [1:0] sel, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] raw);
        m_valid = v; m_pc = pc; m_rd = rd; m_reg_we = we; m_wb_sel = sel;
        m_funct3 = f3; m_addr_lo = lo; m_alu_result = alu; m_load_data = raw;
    endtask

    task automatic set_random();
        set_op(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
               3'($urandom), 2'($urandom), $urandom, $urandom);
    endtask

    initial begin
        longint unsigned c0;

        vecs[0] = '{"lb", 3'b000, 2'd3, 2'd1, 5'd3, 1'b1, 32'h100, 32'h0, 32'h80FF_1234,
                    32'hFFFF_FF80, 1'b1, 32'd3};
        vecs[1] = '{"lbu", 3'b100, 2'd3, 2'd1, 5'd3, 1'b1, 32'h104, 32'h0, 32'h80FF_1234,
                    32'h0000_0080, 1'b1, 32'd3};
        vecs[2] = '{"lh", 3'b001, 2'd2, 2'd1, 5'd4, 1'b1, 32'h108, 32'h0, 32'h80FF_1234,
                    32'hFFFF_80FF, 1'b1, 32'd4};
        vecs[3] = '{"lhu", 3'b101, 2'd2, 2'd1, 5'd4, 1'b1, 32'h10C, 32'h0, 32'h80FF_1234,
                    32'h0000_80FF, 1'b1, 32'd4};
        vecs[4] = '{"lw", 3'b010, 2'd0, 2'd1, 5'd6, 1'b1, 32'h110, 32'h0, 32'h80FF_1234,
                    32'h80FF_1234, 1'b1, 32'd6};
        vecs[5] = '{"alu_x0", 3'b000, 2'd0, 2'd0, 5'd0, 1'b1, 32'h114, 32'hDEAD_BEEF, 32'h0,
                    32'hDEAD_BEEF, 1'b0, 32'd0};
        vecs[6] = '{"jal_wrap", 3'b000, 2'd0, 2'd2, 5'd1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0,
                    32'h0000_0000, 1'b1, 32'd1};

        // Reset with random inputs for two cycles.
        reset = 1; stall = 0; flush = 0;
        set_random(); m_valid = 1;
        step("reset0");
        set_random(); m_valid = 1;
        step("reset1");
        check("reset data", {32'b0, wb_data_rd}, 64'd0);
        check("reset instret", instret, 64'd0);
        reset = 0;
        set_op(1, 32'h40, 5'd2, 1, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0);
        step("first");
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("first_leave");
        check("first instret", instret, 64'd1);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            set_op(1, vecs[i].pc, vecs[i].rd, vecs[i].we, vecs[i].sel, vecs[i].f3,
                   vecs[i].lo, vecs[i].alu, vecs[i].raw);
            step(vecs[i].name);
            check({vecs[i].name, " tbl data"}, {32'b0, wb_data_rd}, {32'b0, vecs[i].exp_data});
            check({vecs[i].name, " tbl we"}, {63'b0, wb_write_enable}, {63'b0, vecs[i].exp_we});
            check({vecs[i].name, " tbl addr"}, {32'b0, wb_addr_rd}, {32'b0, vecs[i].exp_addr});
        end

        // Stall for three cycles with a valid ALU op in WB.
        set_op(1, 32'h200, 5'd7, 1, 2'd0, 3'd0, 2'd0, 32'hCAFE, 32'h0);
        step("stall_load");
        c0 = r_cnt;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_random();
            step("stall_hold");
            check("stall data", {32'b0, wb_data_rd}, 64'hCAFE);
            check("stall we", {63'b0, wb_write_enable}, 64'd1);
            check("stall instret", instret, c0);
        end
        stall = 0;
        set_op(1, 32'h204, 5'd8, 1, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0);
        step("stall_release");
        check("release instret", instret, c0 + 1);
        stall = 1; flush = 1;
        step("stall_flush");
        check("stall_flush valid", {63'b0, wb_valid}, 64'd0);
        check("stall_flush instret", instret, c0 + 2);
        stall = 0; flush = 0;

        // Reset during a stall discards the occupant uncounted.
        set_op(1, 32'h300, 5'd9, 1, 2'd0, 3'd0, 2'd0, 32'h99, 32'h0);
        step("pre_reset");
        stall = 1; reset = 1;
        step("reset_stall");
        check("reset_stall instret", instret, 64'd0);
        stall = 0; reset = 0;

        // Back-to-back writes to x5.
        set_op(1, 32'h400, 5'd5, 1, 2'd0, 3'd0, 2'd0, 32'h11, 32'h0);
        step("x5_a");
        check("x5 first data", {32'b0, wb_data_rd}, 64'h11);
        set_op(1, 32'h404, 5'd5, 1, 2'd0, 3'd0, 2'd0, 32'h22, 32'h0);
        step("x5_b");
        check("x5 second data", {32'b0, wb_data_rd}, 64'h22);
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("x5_idle");
        check("x5 regfile", {32'b0, regs[5]}, 64'h22);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_random();
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
